ram_arbiter: RTL and testbench

Two-port arbiter that shares the FRANK6000 single-port synchronous RAM between two requesters: port 0 (CPU load/store/fetch) and port 1 (boot loader / DMA). It grants at most one access per clock, using round-robin on contention, and supports a lock for atomic multi-access sequences. It drives the RAM's address, data and write-enable pins, and returns read data with a one-cycle valid strobe to the requester that issued the read. It sits between the CPU/loader and the RAM instance, and is the only block driving the RAM.

---
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two requesters.
// Port 0 is the CPU and port 1 is the boot loader / DMA. The arbiter grants at most one
// access per clock, alternates between the ports when both request, and lets a port lock
// ownership across an atomic sequence of accesses.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   reqN, weN, lockN  request, write enable and lock-hold for port N
//   addrN, wdataN     address and write data for port N
//   gntN              combinational grant (access taken at this rising edge)
//   rvalidN           registered; rdata holds port N's read result this cycle
//   rdata             shared read data, wired straight from ram_dout
//   owner_locked      registered; a lock is currently held
//   ram_addr/din/we   RAM drive pins
//   ram_dout          RAM read data
module ram_arbiter #(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] wdata0,
    input  logic [data_width-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [data_width-1:0] rdata,
    output logic                  owner_locked,
    output logic [addr_width-1:0] ram_addr,
    output logic [data_width-1:0] ram_din,
    output logic                  ram_we,
    input  logic [data_width-1:0] ram_dout
);

    logic last_q;     // last granted port
    logic lk_q;       // lock held
    logic lk_port_q;  // port holding the lock
    logic rv0_q;
    logic rv1_q;

    // Grant decision
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (lk_q) begin
                // Only the owner may be granted; the other port is shut out.
                if (lk_port_q) begin
                    gnt1 = req1;
                end else begin
                    gnt0 = req0;
                end
            end else if (req0 && req1) begin
                // Round-robin: the port not served last wins the tie.
                if (last_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // RAM drive; port 0 signals are presented when nothing is granted.
    always_comb begin
        if (gnt1) begin
            ram_addr = addr1;
            ram_din  = wdata1;
            ram_we   = we1;
        end else begin
            ram_addr = addr0;
            ram_din  = wdata0;
            ram_we   = we0 & gnt0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            lk_q      <= 1'b0;
            lk_port_q <= 1'b0;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
        end else begin
            rv0_q <= gnt0 & ~we0;
            rv1_q <= gnt1 & ~we1;
            // With no grant the lock state is kept, so an owner may idle while locked.
            if (gnt0) begin
                last_q <= 1'b0;
                lk_q   <= lock0;
                if (lock0) begin
                    lk_port_q <= 1'b0;
                end
            end else if (gnt1) begin
                last_q <= 1'b1;
                lk_q   <= lock1;
                if (lock1) begin
                    lk_port_q <= 1'b1;
                end
            end
        end
    end

    assign rvalid0      = rv0_q;
    assign rvalid1      = rv1_q;
    assign owner_locked = lk_q;
    assign rdata        = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, owner_locked, ram_we;
    logic [7:0] rdata, ram_addr, ram_din, ram_dout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    logic [7:0] mem [256];

    ram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .lock0        (lock0),
        .lock1        (lock1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .owner_locked (owner_locked),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_dout     (ram_dout)
    );

    // Single-port synchronous RAM model
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge and check read strobes / data against the scoreboard.
    task automatic tick(input string tag, input logic elk);
        logic e0, e1;
        @(posedge clk);
        #1;
        e0 = (q0.size() != 0);
        e1 = (q1.size() != 0);
        chk({tag, ".rvalid0"}, {31'd0, rvalid0}, {31'd0, e0});
        chk({tag, ".rvalid1"}, {31'd0, rvalid1}, {31'd0, e1});
        if (e0) chk({tag, ".rdata0"}, {24'd0, rdata}, {24'd0, q0.pop_front()});
        if (e1) chk({tag, ".rdata1"}, {24'd0, rdata}, {24'd0, q1.pop_front()});
        chk({tag, ".owner_locked"}, {31'd0, owner_locked}, {31'd0, elk});
    endtask

    task automatic step(input string tag,
                        input logic r0, input logic w0, input logic l0,
                        input logic [7:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic l1,
                        input logic [7:0] a1, input logic [7:0] d1,
                        input logic eg0, input logic eg1,
                        input logic [7:0] ed0, input logic [7:0] ed1,
                        input logic elk);
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        #1;
        chk({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, eg0});
        chk({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, eg1});
        chk({tag, ".ram_we"}, {31'd0, ram_we}, {31'd0, (eg0 & w0) | (eg1 & w1)});
        if (eg0 || eg1) chk({tag, ".ram_addr"}, {24'd0, ram_addr}, {24'd0, eg1 ? a1 : a0});
        if (eg0 && !w0) q0.push_back(ed0);
        if (eg1 && !w1) q1.push_back(ed1);
        tick(tag, elk);
    endtask

    task automatic rst_step(input string tag, input logic r0, input logic r1);
        rst = 1'b1;
        req0 = r0; we0 = 1'b0; lock0 = 1'b0; addr0 = 8'h10; wdata0 = 8'h00;
        req1 = r1; we1 = 1'b0; lock1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h00;
        #1;
        chk({tag, ".gnt0"}, {31'd0, gnt0}, 32'd0);
        chk({tag, ".gnt1"}, {31'd0, gnt1}, 32'd0);
        chk({tag, ".ram_we"}, {31'd0, ram_we}, 32'd0);
        // Reads in flight are dropped by reset.
        q0.delete();
        q1.delete();
        tick(tag, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rst_step("rst_a", 1'b1, 1'b1);
        rst_step("rst_b", 1'b1, 1'b1);

        // Port 0 wins the first tie after reset.
        step("first_tie", 1,1,0, 8'h20,8'h5A, 1,1,0, 8'h10,8'hA5, 1,0, 8'h00,8'h00, 0);
        // Port 1 write then read.
        step("p1_write",  0,0,0, 8'h00,8'h00, 1,1,0, 8'h10,8'hA5, 0,1, 8'h00,8'h00, 0);
        step("p1_read",   0,0,0, 8'h00,8'h00, 1,0,0, 8'h10,8'h00, 0,1, 8'h00,8'hA5, 0);

        // Contention: alternating grants starting with port 0.
        for (int i = 0; i < 6; i++) begin
            step($sformatf("cont%0d", i), 1,0,0, 8'h20,8'h00, 1,0,0, 8'h10,8'h00,
                 (i % 2) == 0, (i % 2) == 1, 8'h5A, 8'hA5, 0);
        end

        // Lock: three locked accesses, then a releasing fourth.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("lock%0d", i), 1,0,1, 8'h20,8'h00, 1,0,0, 8'h10,8'h00,
                 1, 0, 8'h5A, 8'hA5, 1);
        end
        step("lock_rel",  1,0,0, 8'h20,8'h00, 1,0,0, 8'h10,8'h00, 1,0, 8'h5A,8'hA5, 0);
        step("after_rel", 1,0,0, 8'h20,8'h00, 1,0,0, 8'h10,8'h00, 0,1, 8'h5A,8'hA5, 0);

        // Owner idles while holding the lock; reset clears it.
        step("idle_lock", 1,0,1, 8'h20,8'h00, 1,0,0, 8'h10,8'h00, 1,0, 8'h5A,8'hA5, 1);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("idle%0d", i), 0,0,0, 8'h20,8'h00, 1,0,0, 8'h10,8'h00,
                 0, 0, 8'h00, 8'h00, 1);
        end
        rst_step("rst_lock", 1'b0, 1'b1);
        step("post_rst",  0,0,0, 8'h00,8'h00, 1,0,0, 8'h10,8'h00, 0,1, 8'h00,8'hA5, 0);

        // Write by port 0 then read by port 1 of the same address.
        step("raw_wr",    1,1,0, 8'hFF,8'h3C, 0,0,0, 8'h00,8'h00, 1,0, 8'h00,8'h00, 0);
        step("raw_rd",    0,0,0, 8'h00,8'h00, 1,0,0, 8'hFF,8'h00, 0,1, 8'h00,8'h3C, 0);
        step("drain",     0,0,0, 8'h00,8'h00, 0,0,0, 8'h00,8'h00, 0,0, 8'h00,8'h00, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
